pipe_stall_seq: RTL and testbench

//  Pipeline stall/flush sequencer for the 5-stage RV32I core; consumer of the D_X_M_W stall vector

---
 rtl/pipe_stall_seq_pkg.sv | 24 ++
 rtl/pipe_stall_seq_if.sv | 48 ++++
 rtl/pipe_stall_seq_perf_cnt.sv | 29 ++
 rtl/pipe_stall_seq.sv | 174 +++++++++++++++++
 tb/tb_pipe_stall_seq.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stall_seq_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state
// encoding and bit positions inside the D_X_M_W hazard/valid vectors.
package core_pkg;

    // Sequencer operating modes.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } seq_state_e;

    // Bit positions inside any D_X_M_W ordered 4-bit vector.
    localparam int unsigned NUM_STG = 4;
    localparam int unsigned STG_D   = 3;
    localparam int unsigned STG_X   = 2;
    localparam int unsigned STG_M   = 1;
    localparam int unsigned STG_W   = 0;

    // Width of a counter that has to hold the value 0..limit inclusive.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/pipe_stall_seq_if.sv
// Bundle between hazard control / memories (master) and the stall sequencer
// (slave): hazard requests in, per-stage enables, flushes, valids and
// performance counters out.
interface pipe_stall_seq_if #(
    parameter int unsigned CNT_W = 32
) ();
    import core_pkg::*;

    // Requests from hazard control and the memories.
    logic [NUM_STG-1:0] stall_req;
    logic               br_taken;
    logic               imem_busy;
    logic               dmem_busy;

    // Controls toward the pipeline registers.
    logic               en_pc;
    logic               en_fd;
    logic               en_dx;
    logic               en_xm;
    logic               en_mw;
    logic               flush_fd;
    logic               flush_dx;

    // Status and performance counters.
    logic               valid_d;
    logic               valid_x;
    logic               valid_m;
    logic               valid_w;
    logic               halt_err;
    logic [CNT_W-1:0]   cnt_retire;
    logic [CNT_W-1:0]   cnt_stall;
    logic [CNT_W-1:0]   cnt_flush;

    modport master (
        output stall_req, br_taken, imem_busy, dmem_busy,
        input  en_pc, en_fd, en_dx, en_xm, en_mw, flush_fd, flush_dx,
        input  valid_d, valid_x, valid_m, valid_w, halt_err,
        input  cnt_retire, cnt_stall, cnt_flush
    );

    modport slave (
        input  stall_req, br_taken, imem_busy, dmem_busy,
        output en_pc, en_fd, en_dx, en_xm, en_mw, flush_fd, flush_dx,
        output valid_d, valid_x, valid_m, valid_w, halt_err,
        output cnt_retire, cnt_stall, cnt_flush
    );

endinterface

// File: rtl/pipe_stall_seq_perf_cnt.sv
// Free-running wrap-around event counter with increment enable and
// synchronous clear.
module perf_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: wraps modulo 2^W, never saturates.
    always_comb begin
        cnt_d = inc ? cnt_q + W'(1) : cnt_q;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours regardless of process ordering.
    always_ff @(posedge clk) begin
        if (clr) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stall_seq.sv
// Pipeline stall/flush sequencer for the 5-stage core. Converts hazard
// requests, branch redirects and data-memory wait into per-stage register
// enables and flushes, tracks a valid bit per stage and counts retire,
// stall and flush cycles. A data access that never completes freezes the
// pipe permanently (halt_err) until reset.
module pipe_stall_seq
    import core_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stall_seq_if.slave    bus
);

    localparam int unsigned           WAIT_W     = cnt_width(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0]     WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    seq_state_e          state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                halt_err_q, halt_err_d;
    logic [NUM_STG-1:0]  vld_q, vld_d;

    logic mem_hold;
    logic redirect;
    logic bubble;
    logic en_pc, en_fd, en_dx, en_xm, en_mw;
    logic flush_fd, flush_dx;
    logic counting;

    // W-side stall bits are reserved and deliberately ignored.
    logic unused_stall_bits;
    assign unused_stall_bits = ^bus.stall_req[STG_M:STG_W];

    // Classify this cycle's hazard situation.
    always_comb begin
        // While waiting, the load is known to sit in M, so busy alone holds.
        mem_hold = bus.dmem_busy & ((state_q == DWAIT) | vld_q[STG_M]);
        redirect = bus.br_taken & vld_q[STG_X];
        bubble   = (bus.stall_req[STG_X] & vld_q[STG_X] & vld_q[STG_D])
                 | bus.stall_req[STG_D];
    end

    // Per-stage enables and flushes, highest-priority condition first. The
    // cycle dmem_busy falls inside DWAIT the access completes, so the normal
    // rules apply and M/W captures the returned data.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned and no latch is inferred.
        en_pc    = 1'b1;
        en_fd    = 1'b1;
        en_dx    = 1'b1;
        en_xm    = 1'b1;
        en_mw    = 1'b1;
        flush_fd = 1'b0;
        flush_dx = 1'b0;
        if (rst) begin
            flush_fd = 1'b1;
            flush_dx = 1'b1;
        end else if ((state_q == HALT) || mem_hold) begin
            en_pc = 1'b0;
            en_fd = 1'b0;
            en_dx = 1'b0;
            en_xm = 1'b0;
            en_mw = 1'b0;
        end else if (redirect) begin
            // Wrong-path instructions in D and X are dropped; this also
            // covers a load-use request raised by the wrong-path D slot.
            flush_fd = 1'b1;
            flush_dx = 1'b1;
        end else if (bubble) begin
            // Hold PC and F/D, push one NOP into X.
            en_pc    = 1'b0;
            en_fd    = 1'b0;
            flush_dx = 1'b1;
        end
    end

    // FSM next state, memory wait counter and sticky timeout flag.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        halt_err_d = halt_err_q;
        case (state_q)
            RUN: begin
                if (mem_hold) begin
                    state_d = DWAIT;
                    wait_d  = '0;
                end
            end
            DWAIT: begin
                if (!bus.dmem_busy) begin
                    // Completion wins even on the cycle the limit is reached.
                    state_d = RUN;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_d == WAIT_LIMIT) begin
                        state_d    = HALT;
                        halt_err_d = 1'b1;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Stage valid bits follow the enables and flushes of the registers.
    always_comb begin
        vld_d        = vld_q;
        vld_d[STG_D] = flush_fd ? 1'b0 : (en_fd ? ~bus.imem_busy : vld_q[STG_D]);
        vld_d[STG_X] = flush_dx ? 1'b0 : (en_dx ? vld_q[STG_D]   : vld_q[STG_X]);
        vld_d[STG_M] = en_xm ? vld_q[STG_X] : vld_q[STG_M];
        vld_d[STG_W] = en_mw ? vld_q[STG_M] : vld_q[STG_W];
    end

    // Sequencer state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_q     <= '0;
            halt_err_q <= 1'b0;
            vld_q      <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            halt_err_q <= halt_err_d;
            vld_q      <= vld_d;
        end
    end

    // Counters freeze once the pipe has halted.
    assign counting = (state_q != HALT);

    perf_cnt #(.W(CNT_W)) u_cnt_retire (
        .clk (clk),
        .clr (rst),
        .inc (counting & vld_q[STG_W] & en_mw),
        .cnt (bus.cnt_retire)
    );

    perf_cnt #(.W(CNT_W)) u_cnt_stall (
        .clk (clk),
        .clr (rst),
        .inc (counting & ~en_pc),
        .cnt (bus.cnt_stall)
    );

    perf_cnt #(.W(CNT_W)) u_cnt_flush (
        .clk (clk),
        .clr (rst),
        .inc (counting & ~rst & redirect & flush_fd),
        .cnt (bus.cnt_flush)
    );

    assign bus.en_pc    = en_pc;
    assign bus.en_fd    = en_fd;
    assign bus.en_dx    = en_dx;
    assign bus.en_xm    = en_xm;
    assign bus.en_mw    = en_mw;
    assign bus.flush_fd = flush_fd;
    assign bus.flush_dx = flush_dx;
    assign bus.valid_d  = vld_q[STG_D];
    assign bus.valid_x  = vld_q[STG_X];
    assign bus.valid_m  = vld_q[STG_M];
    assign bus.valid_w  = vld_q[STG_W];
    assign bus.halt_err = halt_err_q;

endmodule

// File: tb/tb_pipe_stall_seq.sv
// Scoreboard bench for pipe_stall_seq. The reference model moves numbered
// instruction tokens through four slots (D, X, M, W); each cycle it decides
// one pipe action from the hazard rules and derives the expected enables,
// valids and counters from that action.
module tb_pipe_stall_seq;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipe_stall_seq_if #(.CNT_W(CNT_W)) bus ();

    pipe_stall_seq #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum {A_RESET, A_FREEZE, A_REDIRECT, A_BUBBLE, A_ADVANCE} act_e;

    typedef struct {
        int               idx;
        logic [6:0]       ctl;    // {pc, fd, dx, xm, mw, flush_fd, flush_dx}
        logic [3:0]       valid;  // {d, x, m, w}
        logic             halt;
        logic [CNT_W-1:0] retire;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
    } exp_t;

    exp_t exp_q[$];

    int n_vectors    = 0;
    int n_miscompare = 0;
    int n_issued     = 0;

    // Reference model: slot[0]=D .. slot[3]=W, token id or -1 for a bubble.
    int slot[4];
    bit waiting;
    int wait_cnt;
    bit halted;
    int next_id;
    int n_retire, n_stall, n_flush;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) slot[i] = -1;
        waiting  = 1'b0;
        wait_cnt = 0;
        halted   = 1'b0;
        n_retire = 0;
        n_stall  = 0;
        n_flush  = 0;
    endtask

    task automatic model_step(input bit r, input logic [3:0] sreq, input logic br,
                              input logic ib, input logic db, output exp_t e);
        act_e act;
        e.idx    = n_issued;
        e.valid  = {slot[0] >= 0, slot[1] >= 0, slot[2] >= 0, slot[3] >= 0};
        e.halt   = halted;
        e.retire = CNT_W'(n_retire);
        e.stall  = CNT_W'(n_stall);
        e.flush  = CNT_W'(n_flush);

        if (r)                                                   act = A_RESET;
        else if (halted)                                         act = A_FREEZE;
        else if (db && (waiting || slot[2] >= 0))                act = A_FREEZE;
        else if (br && slot[1] >= 0)                             act = A_REDIRECT;
        else if ((sreq[2] && slot[1] >= 0 && slot[0] >= 0) || sreq[3]) act = A_BUBBLE;
        else                                                     act = A_ADVANCE;

        case (act)
            A_RESET:    e.ctl = 7'b1111111;
            A_FREEZE:   e.ctl = 7'b0000000;
            A_REDIRECT: e.ctl = 7'b1111111;
            A_BUBBLE:   e.ctl = 7'b0011101;
            default:    e.ctl = 7'b1111100;
        endcase

        if (act == A_RESET) begin
            model_reset();
        end else begin
            if (act != A_FREEZE && slot[3] >= 0) n_retire++;
            if (!halted && (act == A_FREEZE || act == A_BUBBLE)) n_stall++;
            if (act == A_REDIRECT) n_flush++;
            if (act == A_FREEZE) begin
                if (!halted) begin
                    if (!waiting) begin
                        waiting  = 1'b1;
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                        if (wait_cnt >= MEM_TIMEOUT) halted = 1'b1;
                    end
                end
            end else begin
                waiting = 1'b0;
                slot[3] = slot[2];
                slot[2] = slot[1];
                case (act)
                    A_ADVANCE: begin
                        slot[1] = slot[0];
                        if (ib) slot[0] = -1;
                        else begin
                            slot[0] = next_id;
                            next_id++;
                        end
                    end
                    A_REDIRECT: begin
                        slot[1] = -1;
                        slot[0] = -1;
                    end
                    default: slot[1] = -1;  // bubble: D holds
                endcase
            end
        end
    endtask

    // Issue one cycle of stimulus and queue what the DUT must show for it.
    task automatic apply(input bit r, input logic [3:0] sreq, input logic br,
                         input logic ib, input logic db);
        exp_t e;
        @(negedge clk);
        #1;
        model_step(r, sreq, br, ib, db, e);
        exp_q.push_back(e);
        n_issued++;
        rst           = r;
        bus.stall_req = sreq;
        bus.br_taken  = br;
        bus.imem_busy = ib;
        bus.dmem_busy = db;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miscompare++;
            $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Monitor: sample mid-cycle, away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vectors++;
                check("ctl", e.idx,
                      32'({bus.en_pc, bus.en_fd, bus.en_dx, bus.en_xm, bus.en_mw,
                           bus.flush_fd, bus.flush_dx}), 32'(e.ctl));
                check("valid", e.idx,
                      32'({bus.valid_d, bus.valid_x, bus.valid_m, bus.valid_w}), 32'(e.valid));
                check("halt_err", e.idx, 32'(bus.halt_err), 32'(e.halt));
                check("cnt_retire", e.idx, 32'(bus.cnt_retire), 32'(e.retire));
                check("cnt_stall", e.idx, 32'(bus.cnt_stall), 32'(e.stall));
                check("cnt_flush", e.idx, 32'(bus.cnt_flush), 32'(e.flush));
            end
        end
    end

    initial begin
        int burst;
        logic [3:0] sreq;
        bit r;
        next_id = 0;
        burst   = 0;
        model_reset();
        rst           = 1'b1;
        bus.stall_req = 4'b0000;
        bus.br_taken  = 1'b0;
        bus.imem_busy = 1'b0;
        bus.dmem_busy = 1'b0;
        @(posedge clk);

        // Reset held, then a free-running fill.
        apply(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(8);
        // Load-use bubble.
        apply(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
        idle(2);
        // Branch overriding load-use.
        apply(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        idle(5);
        // Short data-memory wait.
        for (int i = 0; i < 3; i++) apply(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        idle(5);
        // Two fetch holes.
        for (int i = 0; i < 2; i++) apply(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        idle(6);
        // Decode stall, and reserved bits that must be ignored.
        apply(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 4'b0011, 1'b0, 1'b0, 1'b0);
        idle(4);
        // Longest wait that still completes.
        for (int i = 0; i < MEM_TIMEOUT; i++) apply(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        idle(4);
        // Stuck memory: timeout, frozen pipe, then reset recovery.
        for (int i = 0; i < MEM_TIMEOUT + 4; i++) apply(1'b0, 4'b0100, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) apply(1'b0, 4'b1000, 1'b1, 1'b1, 1'b0);
        apply(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(6);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (burst == 0 && $urandom_range(0, 11) == 0)
                burst = ($urandom_range(0, 9) == 0) ? MEM_TIMEOUT + 3 : $urandom_range(1, 5);
            sreq[3] = ($urandom_range(0, 9) == 0);
            sreq[2] = ($urandom_range(0, 4) == 0);
            sreq[1] = 1'($urandom_range(0, 1));
            sreq[0] = 1'($urandom_range(0, 1));
            r = halted ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 599) == 0);
            apply(r, sreq, $urandom_range(0, 6) == 0, $urandom_range(0, 5) == 0, burst > 0);
            if (burst > 0) burst--;
        end
        idle(2);

        repeat (3) @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_miscompare++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompare);
        $finish;
    end

endmodule
